seq_scan_sched: RTL and testbench

Round-robin scheduler that shares one serial pattern-match lane among `N_REQ` requesters. Each requester presents a `FRAME_W`-bit frame. The scheduler:

- grants one requester at a time,
- serializes the granted frame MSB-first into the match core,
- counts overlapping occurrences of `PATTERN`,
- returns the count with a one-cycle `done` pulse tagged with the requester id.

It sits in front of the serial sequence detectors and time-multiplexes them.

---
 rtl/seq_sched_pkg.sv | 37 +++
 rtl/seq_scan_sched_if.sv | 36 +++
 rtl/seq_match_core.sv | 51 +++++
 rtl/seq_scan_sched.sv | 163 ++++++++++++++++
 tb/tb_seq_scan_sched.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/seq_sched_pkg.sv
// seq_sched_pkg: shared types and helpers for the sequence-scan scheduler.
//   state_e   - scheduler FSM state (IDLE, LOAD, SHIFT, REPORT), 2-bit
//   DEF_*     - default pattern constants (5'b10110, length 5)
//   rr_pick   - round-robin pick: first set request after 'last', wrapping
package seq_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SHIFT  = 2'd2,
        REPORT = 2'd3
    } state_e;

    localparam int                     DEF_PAT_LEN = 5;
    localparam logic [DEF_PAT_LEN-1:0] DEF_PATTERN = 5'b10110;

    // Search starts at last+1 and wraps over n requesters (n <= 8).
    // Returns 'last' if nothing is requested; callers gate on |req.
    function automatic logic [2:0] rr_pick(input logic [7:0] req,
                                           input logic [2:0] last,
                                           input int         n);
        logic [2:0] pick;
        logic       found;
        int         idx;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            idx = (int'(last) + k) % n;
            if (k <= n && !found && req[idx[2:0]]) begin
                pick  = idx[2:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/seq_scan_sched_if.sv
// seq_scan_sched_if: requester-side bus of the sequence-scan scheduler.
//   req/frame_data       - requests and per-requester frames (master drives)
//   gnt/busy/done        - one-hot grant, activity, one-cycle completion pulse
//   done_id/match_cnt    - result tag and overlapping match count
//   first_hit/first_pos  - only with SEQ_SCHED_FIRSTPOS_EN defined
interface seq_scan_sched_if #(
    parameter int N_REQ   = 4,
    parameter int FRAME_W = 16,
    parameter int CNT_W   = 5
);
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]         req;
    logic [N_REQ*FRAME_W-1:0] frame_data;
    logic [N_REQ-1:0]         gnt;
    logic                     busy;
    logic                     done;
    logic [ID_W-1:0]          done_id;
    logic [CNT_W-1:0]         match_cnt;

`ifdef SEQ_SCHED_FIRSTPOS_EN
    logic                       first_hit;
    logic [$clog2(FRAME_W)-1:0] first_pos;

    modport master (output req, frame_data,
                    input  gnt, busy, done, done_id, match_cnt, first_hit, first_pos);
    modport slave  (input  req, frame_data,
                    output gnt, busy, done, done_id, match_cnt, first_hit, first_pos);
`else
    modport master (output req, frame_data,
                    input  gnt, busy, done, done_id, match_cnt);
    modport slave  (input  req, frame_data,
                    output gnt, busy, done, done_id, match_cnt);
`endif

endinterface

// File: rtl/seq_match_core.sv
// seq_match_core: serial overlapping pattern detector.
//   clk, reset_n - clock, async active-low reset
//   clr          - clears history and armed count (start of a frame)
//   bit_in/vld   - next serial bit, MSB of the frame first
//   hit          - history equals PATTERN and at least PAT_LEN bits seen;
//                  combinational on the registered history
module seq_match_core
    import seq_sched_pkg::*;
#(
    parameter int                 PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic bit_in,
    input  logic bit_vld,
    output logic hit
);
    localparam int AW = $clog2(PAT_LEN + 1);

    logic [PAT_LEN-1:0] hist_q, hist_d;
    logic [AW-1:0]      armed_q, armed_d;

    always_comb begin
        hist_d  = hist_q;
        armed_d = armed_q;
        if (clr) begin
            hist_d  = '0;
            armed_d = '0;
        end else if (bit_vld) begin
            hist_d = {hist_q[PAT_LEN-2:0], bit_in};
            // Saturates once the window is full; history is never cleared
            // on a hit, so overlapping matches are counted.
            if (armed_q != AW'(PAT_LEN)) armed_d = armed_q + AW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist_q  <= '0;
            armed_q <= '0;
        end else begin
            hist_q  <= hist_d;
            armed_q <= armed_d;
        end
    end

    assign hit = (armed_q == AW'(PAT_LEN)) && (hist_q == PATTERN);

endmodule

// File: rtl/seq_scan_sched.sv
// seq_scan_sched: round-robin scheduler sharing one serial match lane.
//   clk, reset_n - clock, async active-low reset
//   bus (slave)  - req/frame_data in; gnt/busy/done/done_id/match_cnt out
// Optional feature macro: SEQ_SCHED_FIRSTPOS_EN adds first_hit/first_pos.
// Timeline per frame: IDLE, LOAD, FRAME_W x SHIFT, REPORT.
module seq_scan_sched
    import seq_sched_pkg::*;
#(
    parameter int                 N_REQ   = 4,
    parameter int                 FRAME_W = 16,
    parameter int                 PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN,
    parameter int                 CNT_W   = 5
) (
    input  logic                    clk,
    input  logic                    reset_n,
    seq_scan_sched_if.slave         bus
);
    localparam int ID_W = $clog2(N_REQ);
    localparam int BC_W = $clog2(FRAME_W + 1);
    localparam int FP_W = $clog2(FRAME_W);

    state_e             state_q, state_d;
    logic [ID_W-1:0]    last_q, last_d, id_q, id_d, hold_id_q, hold_id_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [FRAME_W-1:0] sh_q, sh_d;
    logic [BC_W-1:0]    bc_q, bc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, hold_cnt_q, hold_cnt_d, cnt_fin;
    logic [ID_W-1:0]    pick_id;
    logic               core_clr, core_vld, hit;

    seq_match_core #(.PAT_LEN(PAT_LEN), .PATTERN(PATTERN)) u_core (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (core_clr),
        .bit_in  (sh_q[FRAME_W-1]),
        .bit_vld (core_vld),
        .hit     (hit)
    );

    assign pick_id = ID_W'(rr_pick(8'(bus.req), 3'(last_q), N_REQ));

    // hit lags the shifted bit by one cycle, so the last bit's hit lands in
    // REPORT; cnt_fin folds it in so the reported count is complete.
    assign cnt_fin = (hit && cnt_q != {CNT_W{1'b1}}) ? cnt_q + CNT_W'(1) : cnt_q;

`ifdef SEQ_SCHED_FIRSTPOS_EN
    logic            fh_q, fh_d, hold_fh_q, hold_fh_d, fh_fin;
    logic [FP_W-1:0] fp_q, fp_d, hold_fp_q, hold_fp_d, fp_fin;
    // A hit seen now refers to the bit shifted in last cycle: index bc_q-1.
    assign fh_fin = fh_q | hit;
    assign fp_fin = (hit && !fh_q) ? FP_W'(bc_q - BC_W'(1)) : fp_q;
`endif

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        id_d       = id_q;
        gnt_d      = gnt_q;
        sh_d       = sh_q;
        bc_d       = bc_q;
        cnt_d      = cnt_q;
        hold_id_d  = hold_id_q;
        hold_cnt_d = hold_cnt_q;
        core_clr   = 1'b0;
        core_vld   = 1'b0;
`ifdef SEQ_SCHED_FIRSTPOS_EN
        fh_d      = fh_q;
        fp_d      = fp_q;
        hold_fh_d = hold_fh_q;
        hold_fp_d = hold_fp_q;
`endif
        case (state_q)
            IDLE: if (|bus.req) begin
                id_d    = pick_id;
                last_d  = pick_id;
                gnt_d   = N_REQ'(1) << pick_id;
                state_d = LOAD;
            end
            LOAD: begin
                sh_d     = bus.frame_data[int'(id_q)*FRAME_W +: FRAME_W];
                bc_d     = '0;
                cnt_d    = '0;
                core_clr = 1'b1;
`ifdef SEQ_SCHED_FIRSTPOS_EN
                fh_d = 1'b0;
                fp_d = '0;
`endif
                state_d  = SHIFT;
            end
            SHIFT: begin
                core_vld = 1'b1;
                sh_d     = {sh_q[FRAME_W-2:0], 1'b0};
                bc_d     = bc_q + BC_W'(1);
                cnt_d    = cnt_fin;
`ifdef SEQ_SCHED_FIRSTPOS_EN
                fh_d = fh_fin;
                fp_d = fp_fin;
`endif
                if (bc_q == BC_W'(FRAME_W - 1)) state_d = REPORT;
            end
            REPORT: begin
                hold_id_d  = id_q;
                hold_cnt_d = cnt_fin;
`ifdef SEQ_SCHED_FIRSTPOS_EN
                hold_fh_d = fh_fin;
                hold_fp_d = fp_fin;
`endif
                gnt_d      = '0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            last_q     <= ID_W'(N_REQ - 1);
            id_q       <= '0;
            gnt_q      <= '0;
            sh_q       <= '0;
            bc_q       <= '0;
            cnt_q      <= '0;
            hold_id_q  <= '0;
            hold_cnt_q <= '0;
`ifdef SEQ_SCHED_FIRSTPOS_EN
            fh_q      <= 1'b0;
            fp_q      <= '0;
            hold_fh_q <= 1'b0;
            hold_fp_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            id_q       <= id_d;
            gnt_q      <= gnt_d;
            sh_q       <= sh_d;
            bc_q       <= bc_d;
            cnt_q      <= cnt_d;
            hold_id_q  <= hold_id_d;
            hold_cnt_q <= hold_cnt_d;
`ifdef SEQ_SCHED_FIRSTPOS_EN
            fh_q      <= fh_d;
            fp_q      <= fp_d;
            hold_fh_q <= hold_fh_d;
            hold_fp_q <= hold_fp_d;
`endif
        end
    end

    // Results are live in REPORT and held from the hold registers afterwards.
    assign bus.gnt       = gnt_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == REPORT);
    assign bus.done_id   = bus.done ? id_q : hold_id_q;
    assign bus.match_cnt = bus.done ? cnt_fin : hold_cnt_q;
`ifdef SEQ_SCHED_FIRSTPOS_EN
    assign bus.first_hit = bus.done ? fh_fin : hold_fh_q;
    assign bus.first_pos = bus.done ? fp_fin : hold_fp_q;
`endif

endmodule

// File: tb/tb_seq_scan_sched.sv
// Directed bench for seq_scan_sched: vector table plus hand sequences for
// fairness, frame isolation, saturation (second instance, CNT_W=2) and
// asynchronous reset mid-scan. First-match checks follow SEQ_SCHED_FIRSTPOS_EN.
module tb_seq_scan_sched;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   checks  = 0;
    int   errors  = 0;

    always #5 clk = ~clk;

    seq_scan_sched_if #(.N_REQ(4), .FRAME_W(16), .CNT_W(5)) mb ();
    seq_scan_sched_if #(.N_REQ(4), .FRAME_W(16), .CNT_W(2)) sb ();

    seq_scan_sched #(.N_REQ(4), .FRAME_W(16), .PAT_LEN(5), .PATTERN(5'b10110), .CNT_W(5))
        u_dut (.clk(clk), .reset_n(reset_n), .bus(mb));
    seq_scan_sched #(.N_REQ(4), .FRAME_W(16), .PAT_LEN(5), .PATTERN(5'b10110), .CNT_W(2))
        u_sat (.clk(clk), .reset_n(reset_n), .bus(sb));

    typedef struct {
        int          id;
        logic [15:0] frame;
        int          cnt;
        int          fh;
        int          fp;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    // Single-requester scan: req raised at a negedge while IDLE; negedge k
    // afterwards is cycle k. Expect gnt at cycle 1 and done at cycle 18.
    task automatic scan(input bit sat, input int id, input logic [15:0] f,
                        input int exp_cnt, input int exp_fh, input int exp_fp,
                        input string nm);
        int gcyc, dcyc;
        logic [3:0] g;
        gcyc = -1;
        dcyc = -1;
        if (sat) begin
            sb.frame_data[id*16 +: 16] = f;
            sb.req = 4'b0001 << id;
        end else begin
            mb.frame_data[id*16 +: 16] = f;
            mb.req = 4'b0001 << id;
        end
        for (int k = 1; k <= 40 && dcyc < 0; k++) begin
            @(negedge clk);
            g = sat ? sb.gnt : mb.gnt;
            if (gcyc < 0 && g != 4'b0) begin
                gcyc = k;
                chk({nm, "_gnt"}, int'(g), 1 << id);
                if (sat) sb.req = 4'b0; else mb.req = 4'b0;
            end
            if ((sat ? sb.done : mb.done) == 1'b1) begin
                dcyc = k;
                chk({nm, "_done_id"}, sat ? int'(sb.done_id) : int'(mb.done_id), id);
                chk({nm, "_cnt"}, sat ? int'(sb.match_cnt) : int'(mb.match_cnt), exp_cnt);
`ifdef SEQ_SCHED_FIRSTPOS_EN
                chk({nm, "_first_hit"}, sat ? int'(sb.first_hit) : int'(mb.first_hit), exp_fh);
                chk({nm, "_first_pos"}, sat ? int'(sb.first_pos) : int'(mb.first_pos), exp_fp);
`endif
            end
        end
        chk({nm, "_gnt_cycle"}, gcyc, 1);
        chk({nm, "_done_cycle"}, dcyc, 18);
        @(negedge clk);
        chk({nm, "_done_low"}, sat ? int'(sb.done) : int'(mb.done), 0);
    endtask

    initial begin
        int   dcnt;
        logic seen;

        mb.req = '0; mb.frame_data = '0;
        sb.req = '0; sb.frame_data = '0;

        vecs[0] = '{0, 16'hB600, 2, 1, 4};   // 1011_0110_0000_0000
        vecs[1] = '{1, 16'h0000, 0, 0, 0};
        vecs[2] = '{2, 16'hFFFF, 0, 0, 0};
        vecs[3] = '{3, 16'h0016, 1, 1, 15};  // match on the very last bit
        vecs[4] = '{0, 16'hB6DB, 4, 1, 4};   // four overlapping matches
        vecs[5] = '{2, 16'h5AC0, 2, 1, 5};
        vecs[6] = '{0, 16'h000B, 0, 0, 0};   // ends in 1011
        vecs[7] = '{1, 16'h0000, 0, 0, 0};   // would match if history leaked

        #1;
        chk("rst_gnt",   int'(mb.gnt), 0);
        chk("rst_busy",  int'(mb.busy), 0);
        chk("rst_done",  int'(mb.done), 0);
        chk("rst_id",    int'(mb.done_id), 0);
        chk("rst_cnt",   int'(mb.match_cnt), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++)
            scan(1'b0, vecs[i].id, vecs[i].frame, vecs[i].cnt, vecs[i].fh, vecs[i].fp,
                 $sformatf("vec%0d", i));
        chk("hold_id",  int'(mb.done_id), 1);
        chk("hold_busy", int'(mb.busy), 0);

        // Saturation: true count 4 clamps to 3 with a 2-bit counter.
        scan(1'b1, 0, 16'hB6DB, 3, 1, 4, "sat");

        // Fairness: all four held, frame2 carries two matches.
        do_reset();
        mb.frame_data = {16'h0000, 16'hB600, 16'h0000, 16'h0000};
        mb.req = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            seen = 1'b0;
            for (int k = 0; k < 40 && !seen; k++) begin
                @(negedge clk);
                if (mb.done) seen = 1'b1;
            end
            chk($sformatf("rr%0d_seen", i), int'(seen), 1);
            chk($sformatf("rr%0d_id", i), int'(mb.done_id), i % 4);
            chk($sformatf("rr%0d_cnt", i), int'(mb.match_cnt), ((i % 4) == 2) ? 2 : 0);
            @(negedge clk);
            chk($sformatf("rr%0d_idle_gnt", i), int'(mb.gnt), 0);
            chk($sformatf("rr%0d_idle_busy", i), int'(mb.busy), 0);
            if (i == 5) mb.req = 4'b0;
            @(negedge clk);
            chk($sformatf("rr%0d_next_gnt", i), int'(mb.gnt), (i == 5) ? 0 : (1 << ((i + 1) % 4)));
        end
        repeat (20) @(negedge clk);
        dcnt = int'(mb.busy);
        chk("rr_quiet", dcnt, 0);

        // Reset at SHIFT cycle 7 (cycle 8), then rescan the same request.
        mb.frame_data[15:0] = 16'hB600;
        mb.req = 4'b0001;
        repeat (8) @(negedge clk);
        chk("mid_busy_before", int'(mb.busy), 1);
        reset_n = 1'b0;
        #1;
        chk("mid_gnt",  int'(mb.gnt), 0);
        chk("mid_busy", int'(mb.busy), 0);
        chk("mid_done", int'(mb.done), 0);
        @(negedge clk);
        reset_n = 1'b1;
        scan(1'b0, 0, 16'hB600, 2, 1, 4, "rescan");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
